// File: rtl/ghost_pkg.sv
// rtl/ghost_pkg.sv - shared direction encodings, FSM states and maze defaults for ghost movement
package ghost_pkg;

    localparam logic [3:0] DIR_RIGHT = 4'b0001;
    localparam logic [3:0] DIR_UP    = 4'b0010;
    localparam logic [3:0] DIR_DOWN  = 4'b0100;
    localparam logic [3:0] DIR_LEFT  = 4'b1000;

    localparam int TILE_PX  = 16;
    localparam int X_MIN_PX = 0;
    localparam int X_MAX_PX = 624;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DECIDE = 2'd2,
        ST_STEP   = 2'd3
    } state_t;

    // RIGHT<->LEFT and UP<->DOWN sit mirrored in the one-hot code, so reversing is a bit swap
    function automatic logic [3:0] reverse_dir(input logic [3:0] d);
        return {d[0], d[1], d[2], d[3]};
    endfunction

endpackage

// File: rtl/ghost_pos_update_if.sv
// rtl/ghost_pos_update_if.sv - steering-side inputs and position/status outputs of one ghost
interface ghost_pos_update_if;

    logic        en;
    logic        move_tick;
    logic [3:0]  move_direction;
    logic [3:0]  valid_moves;
    logic [10:0] ghost_pos_x;
    logic [9:0]  ghost_pos_y;
    logic [3:0]  prev_direction;
    logic        busy;
    logic        step_done;
    logic        tick_missed;

    modport master (
        output en, move_tick, move_direction, valid_moves,
        input  ghost_pos_x, ghost_pos_y, prev_direction, busy, step_done, tick_missed
    );

    modport slave (
        input  en, move_tick, move_direction, valid_moves,
        output ghost_pos_x, ghost_pos_y, prev_direction, busy, step_done, tick_missed
    );

endinterface

// File: rtl/ghost_dir_select.sv
// rtl/ghost_dir_select.sv - combinational heading choice at a tile-aligned decision point
module ghost_dir_select
    import ghost_pkg::*;
(
    input  logic [3:0] move_direction,
    input  logic [3:0] valid_moves,
    input  logic [3:0] prev_direction,
    output logic [3:0] next_dir,
    output logic       stall
);

    logic [3:0] rev;
    logic [3:0] open_fwd;
    logic       req_onehot;

    always_comb begin
        rev        = reverse_dir(prev_direction);
        open_fwd   = valid_moves & ~rev;
        req_onehot = (move_direction != 4'd0) &&
                     ((move_direction & 4'(move_direction - 4'd1)) == 4'd0);
        next_dir   = prev_direction;
        stall      = 1'b0;

        if (req_onehot && ((move_direction & valid_moves) != 4'd0) &&
            ((move_direction & rev) == 4'd0)) begin
            next_dir = move_direction;
        end else if ((prev_direction & valid_moves) != 4'd0) begin
            next_dir = prev_direction;
        end else if (open_fwd[1]) begin
            next_dir = DIR_UP;
        end else if (open_fwd[2]) begin
            next_dir = DIR_DOWN;
        end else if (open_fwd[0]) begin
            next_dir = DIR_RIGHT;
        end else if (open_fwd[3]) begin
            next_dir = DIR_LEFT;
        end else if ((rev & valid_moves) != 4'd0) begin
            next_dir = rev;
        end else begin
            stall = 1'b1;
        end
    end

endmodule

// File: rtl/ghost_pos_update.sv
// rtl/ghost_pos_update.sv - per-ghost position/heading register stepping on movement ticks
module ghost_pos_update
    import ghost_pkg::*;
#(
    parameter int START_X       = 320,
    parameter int START_Y       = 240,
    parameter int TILE          = TILE_PX,
    parameter int STEP_PX       = 2,
    parameter int SETTLE_CYCLES = 2,
    parameter int X_MIN         = X_MIN_PX,
    parameter int X_MAX         = X_MAX_PX
)
(
    input  logic              clk,
    input  logic              rst,
    ghost_pos_update_if.slave bus
);

    localparam int TB = $clog2(TILE);
    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    state_t      state, state_nxt;
    logic [CW-1:0] cnt;
    logic [10:0] pos_x;
    logic [9:0]  pos_y;
    logic [3:0]  prev_q;
    logic [3:0]  head_q;
    logic        stall_q;
    logic        step_done_q;
    logic        tick_missed_q;

    logic        aligned;
    logic [3:0]  sel_dir;
    logic        sel_stall;
    logic        load_cnt, dec_cnt, take_dir, hold_dir, commit;
    logic [11:0] x12;
    logic [10:0] nx;
    logic [9:0]  ny;

    assign aligned = (pos_x[TB-1:0] == '0) && (pos_y[TB-1:0] == '0);

    ghost_dir_select u_dir_select (
        .move_direction (bus.move_direction),
        .valid_moves    (bus.valid_moves),
        .prev_direction (prev_q),
        .next_dir       (sel_dir),
        .stall          (sel_stall)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else if (bus.en) begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (bus.move_tick) state_nxt = aligned ? ST_SETTLE : ST_STEP;
            ST_SETTLE: if (cnt == '0) state_nxt = ST_DECIDE;
            ST_DECIDE: state_nxt = ST_STEP;
            ST_STEP:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        load_cnt = 1'b0;
        dec_cnt  = 1'b0;
        take_dir = 1'b0;
        hold_dir = 1'b0;
        commit   = 1'b0;
        case (state)
            ST_IDLE: begin
                load_cnt = bus.move_tick && aligned;
                hold_dir = bus.move_tick && !aligned;
            end
            ST_SETTLE: dec_cnt  = (cnt != '0);
            ST_DECIDE: take_dir = 1'b1;
            ST_STEP:   commit   = 1'b1;
            default:   ;
        endcase
    end

    // Wrap decisions are made at 12 bits so x+STEP_PX near the right edge cannot alias
    always_comb begin
        x12 = {1'b0, pos_x};
        nx  = pos_x;
        ny  = pos_y;
        case (head_q)
            DIR_LEFT:  nx = (x12 < 12'(X_MIN + STEP_PX)) ? 11'(X_MAX) : pos_x - 11'(STEP_PX);
            DIR_RIGHT: nx = ((x12 + 12'(STEP_PX)) > 12'(X_MAX)) ? 11'(X_MIN) : pos_x + 11'(STEP_PX);
            DIR_UP:    ny = pos_y - 10'(STEP_PX);
            DIR_DOWN:  ny = pos_y + 10'(STEP_PX);
            default:   ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pos_x         <= 11'(START_X);
            pos_y         <= 10'(START_Y);
            prev_q        <= DIR_LEFT;
            head_q        <= DIR_LEFT;
            stall_q       <= 1'b0;
            cnt           <= '0;
            step_done_q   <= 1'b0;
            tick_missed_q <= 1'b0;
        end else begin
            tick_missed_q <= bus.move_tick && (!bus.en || (state != ST_IDLE));
            step_done_q   <= 1'b0;
            if (bus.en) begin
                if (load_cnt) cnt <= CW'(SETTLE_CYCLES - 1);
                if (dec_cnt)  cnt <= cnt - 1'b1;
                if (hold_dir) begin
                    head_q  <= prev_q;
                    stall_q <= 1'b0;
                end
                if (take_dir) begin
                    head_q  <= sel_dir;
                    stall_q <= sel_stall;
                end
                if (commit && !stall_q) begin
                    pos_x       <= nx;
                    pos_y       <= ny;
                    prev_q      <= head_q;
                    step_done_q <= 1'b1;
                end
            end
        end
    end

    assign bus.ghost_pos_x    = pos_x;
    assign bus.ghost_pos_y    = pos_y;
    assign bus.prev_direction = prev_q;
    assign bus.busy           = (state != ST_IDLE);
    assign bus.step_done      = step_done_q;
    assign bus.tick_missed    = tick_missed_q;

endmodule

// File: doc/ghost_pos_update.md
Name: ghost_pos_update

Overview:
- Downstream consumer of the ghost steering stage.
- Holds one ghost's pixel position and current heading.
- At each tile-aligned position it samples the steering decision, checks it against the maze's valid moves, and steps the ghost by a fixed pixel count per movement tick.
- Feeds its position and heading back to the steering stage's position and prev_direction inputs; one instance per ghost.

Parameters:
START_X, 320, reset x position in pixels; must be tile-aligned
START_Y, 240, reset y position in pixels; must be tile-aligned
TILE, 16, maze tile size in pixels; power of two
STEP_PX, 2, pixels moved per accepted tick; must divide TILE
SETTLE_CYCLES, 2, cycles to wait after reaching alignment before sampling move_direction (covers the steering stage's registered latency)
X_MIN, 0, left tunnel bound
X_MAX, 624, right tunnel bound; must be tile-aligned

Ports:
clk  in  1  system clock, single clock domain
rst  in  1  synchronous, active-high reset
en  in  1  game running; 0 freezes position and FSM, ticks ignored
move_tick  in  1  one-cycle movement strobe (frame/speed divider)
move_direction  in  4  one-hot steering request (RIGHT 0001, UP 0010, DOWN 0100, LEFT 1000)
valid_moves  in  4  one-hot-per-bit open directions at the current position, same encoding
ghost_pos_x  out  11  current x position
ghost_pos_y  out  10  current y position
prev_direction  out  4  current heading, one-hot
busy  out  1  FSM not in IDLE
step_done  out  1  one-cycle pulse when a position update commits
tick_missed  out  1  one-cycle pulse when move_tick arrives while busy or while en=0

Behaviour:
- Reset, synchronous on rst=1 at posedge clk:
  - ghost_pos_x=START_X, ghost_pos_y=START_Y, prev_direction=LEFT.
  - State IDLE; busy=0, step_done=0, tick_missed=0; settle counter=0.
  - rst mid-operation aborts any SETTLE/STEP with no partial step applied.
- Aligned means ghost_pos_x[log2(TILE)-1:0]==0 and ghost_pos_y[log2(TILE)-1:0]==0.
- FSM states are IDLE, SETTLE, DECIDE, STEP.
- IDLE:
  - move_tick with en=1 and aligned: go to SETTLE and load the counter with SETTLE_CYCLES-1.
  - move_tick with en=1 and not aligned: go to STEP with the heading unchanged.
- SETTLE: decrement each cycle; go to DECIDE when the counter reaches 0.
- DECIDE, single cycle, heading chosen in priority order:
  - Take move_direction if it is exactly one-hot, is set in valid_moves, and is not the reverse of prev_direction.
  - Otherwise keep prev_direction if it is set in valid_moves.
  - Otherwise take the first set bit of valid_moves excluding the reverse, in priority UP, DOWN, RIGHT, LEFT.
  - Otherwise (dead end) take the reverse if it is valid. If nothing is valid, set the stall flag; the heading is unchanged.
  - Go to STEP.
- STEP, single cycle:
  - If not stalled, move STEP_PX pixels along prev_direction. UP decrements y; DOWN increments y.
  - Update the registered outputs, pulse step_done, return to IDLE.
  - A stall returns to IDLE with the position unchanged and step_done=0.
- Latency:
  - Aligned tick to position update: SETTLE_CYCLES+2 cycles.
  - Unaligned tick to position update: 1 cycle.
- Tunnel wrap-around:
  - LEFT with x < X_MIN+STEP_PX: x becomes X_MAX.
  - RIGHT with x+STEP_PX > X_MAX: x becomes X_MIN.
  - Arithmetic is done at 12 bits, then truncated to 11 bits.
  - y never wraps. Vertical bounds are guaranteed by valid_moves.
- Simultaneous events:
  - rst has priority over everything.
  - en=0 holds state and all registers; a tick in that cycle pulses tick_missed.
  - A tick arriving in any non-IDLE state is dropped and pulses tick_missed.
- Outputs are registered. move_direction and valid_moves are sampled only in DECIDE; the unaligned path never samples them.

Decomposition:
- Shared package (ghost_pkg) holds:
  - direction constants RIGHT/UP/DOWN/LEFT;
  - a reverse-direction function;
  - FSM state encoding;
  - default maze constants (TILE, X_MIN, X_MAX).
- One natural sub-module, ghost_dir_select: the combinational DECIDE priority logic (inputs move_direction, valid_moves, prev_direction; outputs next_dir and stall).
- The FSM, counter and position arithmetic stay in the top module.

Test Plan:
1. Reset, then move_tick with move_direction=UP and valid_moves=1010 (UP|LEFT) -> after 4 cycles pos=(320,238), prev_direction=0010, step_done pulses once.
2. Position (322,240) heading RIGHT, tick with move_direction=UP -> 1 cycle later pos=(324,240), prev_direction still RIGHT (unaligned, input ignored).
3. Aligned, prev=RIGHT, move_direction=LEFT (reverse), valid_moves=1001 -> heading stays RIGHT, x advances by 2.
4. Tunnel: pos=(0,240) heading LEFT, valid_moves=1000 -> x=624; pos=(624,240) heading RIGHT -> x=0.
5. Aligned, valid_moves=0000 -> position unchanged, no step_done, busy returns to 0 after 4 cycles.
6. Tick during SETTLE -> tick_missed pulses and the step count is unaffected; rst asserted in SETTLE -> next cycle pos=(320,240), prev=LEFT, busy=0.
